tile_mem_req_arbiter: RTL and testbench

TILE_MEM_REQ_ARBITER -- requirements
Module: tile_mem_req_arbiter

---
 rtl/drac_pkg.sv | 15 +
 rtl/tile_rr_arbiter.sv | 35 +++
 rtl/tile_mem_req_arbiter.sv | 131 +++++++++++++
 tb/tb_tile_mem_req_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared types and width rules for the tile memory request arbiter.
package drac_pkg;

  typedef enum logic {
    FIXED_PRIO,
    ROUND_ROBIN
  } arb_mode_t;

  function automatic int pw_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tile_rr_arbiter.sv
// Rotating-priority grant picker; a pointer of 0 gives plain fixed priority.
module tile_rr_arbiter #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] pos;
  logic        hit;

  // Walk ports starting at ptr, wrapping once past N-1.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!hit && elig[pos[IW-1:0]]) begin
        hit = 1'b1;
        gnt[pos[IW-1:0]] = 1'b1;
        idx = pos[IW-1:0];
      end
    end
  end

  assign any = hit;

endmodule

// File: rtl/tile_mem_req_arbiter.sv
// Multi-port memory request arbiter with wake-up delay, per-port
// outstanding limits and a registered downstream request slot.
module tile_mem_req_arbiter
  import drac_pkg::*;
#(
  parameter int        NumPorts       = 6,
  parameter int        PayloadWidth   = 64,
  parameter arb_mode_t ArbMode        = FIXED_PRIO,
  parameter int        MaxOutstanding = 4,
  parameter int        WakeUpCycles   = 32768
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumPorts-1:0]              req_valid_i,
  output logic [NumPorts-1:0]              req_ready_o,
  input  logic [NumPorts*PayloadWidth-1:0] req_payload_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [PayloadWidth-1:0]          out_payload_o,
  output logic [pw_of(NumPorts)-1:0]       out_portid_o,
  input  logic                             rsp_valid_i,
  input  logic [pw_of(NumPorts)-1:0]       rsp_portid_i,
  output logic                             wake_done_o,
  output logic                             err_o
);

  localparam int PW = pw_of(NumPorts);
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [15:0] WakeMax = 16'(WakeUpCycles);

  logic [15:0]         wake_cnt;
  logic [CW-1:0]       outst [NumPorts];
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       arb_ptr;
  logic [PW-1:0]       gnt_idx;
  logic [NumPorts-1:0] elig;
  logic [NumPorts-1:0] gnt;
  logic                gnt_hit;
  logic                loadable;
  logic                grant;
  logic                rsp_in_range;
  logic                rsp_ok;

  assign wake_done_o = (wake_cnt == WakeMax);

  always_comb begin
    elig = '0;
    for (int p = 0; p < NumPorts; p++) begin
      elig[p] = req_valid_i[p] && wake_done_o &&
                (outst[p] < CW'(MaxOutstanding));
    end
  end

  assign arb_ptr = (ArbMode == ROUND_ROBIN) ? rr_ptr : '0;

  tile_rr_arbiter #(
    .N  (NumPorts),
    .IW (PW)
  ) u_arb (
    .elig (elig),
    .ptr  (arb_ptr),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_hit)
  );

  assign loadable    = !out_valid_o || out_ready_i;
  assign grant       = loadable && gnt_hit;
  assign req_ready_o = grant ? gnt : '0;

  // Responses to idle or nonexistent ports are dropped and flagged.
  assign rsp_in_range = {1'b0, rsp_portid_i} < (PW+1)'(NumPorts);
  assign rsp_ok = rsp_valid_i && rsp_in_range &&
                  (outst[rsp_portid_i] != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wake_cnt <= '0;
    end else if (!wake_done_o) begin
      wake_cnt <= wake_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) outst[p] <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (grant && gnt[p] &&
            !(rsp_ok && rsp_portid_i == PW'(p))) begin
          outst[p] <= outst[p] + CW'(1);
        end else if (rsp_ok && rsp_portid_i == PW'(p) &&
                     !(grant && gnt[p])) begin
          outst[p] <= outst[p] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o   <= 1'b0;
      out_payload_o <= '0;
      out_portid_o  <= '0;
    end else if (loadable) begin
      out_valid_o <= gnt_hit;
      if (gnt_hit) begin
        out_payload_o <=
          req_payload_i[int'(gnt_idx)*PayloadWidth +: PayloadWidth];
        out_portid_o  <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_idx == PW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (rsp_valid_i && !rsp_ok) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_mem_req_arbiter.sv
// Scoreboard bench: fixed-priority and round-robin instances share stimulus.
module tb_tile_mem_req_arbiter;
  import drac_pkg::*;

  localparam int N  = 6;
  localparam int W  = 64;
  localparam int MO = 4;
  localparam int WK = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   pay;
  logic             out_ready;
  logic             rsp_valid;
  logic [2:0]       rsp_portid;

  logic [N-1:0] rdy  [2];
  logic         oval [2];
  logic [W-1:0] opay [2];
  logic [2:0]   opid [2];
  logic         wd   [2];
  logic         er   [2];

  tile_mem_req_arbiter #(
    .NumPorts(N), .PayloadWidth(W), .ArbMode(FIXED_PRIO),
    .MaxOutstanding(MO), .WakeUpCycles(WK)
  ) u_fp (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_payload_i(pay),
    .out_valid_o(oval[0]), .out_ready_i(out_ready),
    .out_payload_o(opay[0]), .out_portid_o(opid[0]),
    .rsp_valid_i(rsp_valid), .rsp_portid_i(rsp_portid),
    .wake_done_o(wd[0]), .err_o(er[0])
  );

  tile_mem_req_arbiter #(
    .NumPorts(N), .PayloadWidth(W), .ArbMode(ROUND_ROBIN),
    .MaxOutstanding(MO), .WakeUpCycles(WK)
  ) u_rr (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_payload_i(pay),
    .out_valid_o(oval[1]), .out_ready_i(out_ready),
    .out_payload_o(opay[1]), .out_portid_o(opid[1]),
    .rsp_valid_i(rsp_valid), .rsp_portid_i(rsp_portid),
    .wake_done_o(wd[1]), .err_o(er[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference state: counts per port, pending requests per instance.
  int   wcnt;
  int   os  [2][N];
  int   rr  [2];
  bit   mov [2];
  bit   merr[2];
  int   last_g [2];
  logic [66:0] q0[$];
  logic [66:0] q1[$];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    wcnt = 0;
    for (int m = 0; m < 2; m++) begin
      rr[m] = 0; mov[m] = 0; merr[m] = 0; last_g[m] = -1;
      for (int p = 0; p < N; p++) os[m][p] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic cyc(input logic [N-1:0] v, input bit ordy,
                     input bit rv, input int rp, input bit r);
    int  g;
    int  p;
    bit  ld;
    bit  wdn;
    bit  dec;
    @(posedge clk);
    #1;
    rst = r; req_valid = v; out_ready = ordy;
    rsp_valid = rv; rsp_portid = 3'(rp);
    for (int k = 0; k < N; k++) pay[k*W +: W] = {$urandom, $urandom};
    #1;
    wdn = (wcnt == WK);
    for (int m = 0; m < 2; m++) begin
      chk(m ? "rr_wake_done" : "fp_wake_done", wd[m], wdn);
      chk(m ? "rr_err" : "fp_err", er[m], merr[m]);
      chk(m ? "rr_out_valid" : "fp_out_valid", oval[m], mov[m]);
      g = -1;
      ld = !mov[m] || ordy;
      if (ld && wdn) begin
        for (int i = 0; i < N; i++) begin
          p = ((m == 1 ? rr[m] : 0) + i) % N;
          if (g < 0 && v[p] && os[m][p] < MO) g = p;
        end
      end
      last_g[m] = g;
      if (!r) begin
        chk(m ? "rr_req_ready" : "fp_req_ready", rdy[m],
            (g < 0) ? 0 : (1 << g));
        dec = rv && rp < N && os[m][rp] > 0;
        if (rv && !dec) merr[m] = 1;
        if (g >= 0) begin
          os[m][g]++;
          if (m == 0) q0.push_back({3'(g), pay[g*W +: W]});
          else        q1.push_back({3'(g), pay[g*W +: W]});
          rr[m] = (g + 1) % N;
        end
        if (dec) os[m][rp]--;
        if (ld) mov[m] = (g >= 0);
      end
    end
    if (r) model_reset();
    else if (wcnt < WK) wcnt++;
  endtask

  task automatic wake_up();
    cyc('0, 1, 0, 0, 1);
    repeat (WK) cyc('0, 1, 0, 0, 0);
  endtask

  // Monitor: transfers pop the scoreboard, stalls must match its head.
  always @(negedge clk) begin
    logic [66:0] e;
    if (rst === 1'b0) begin
      if (oval[0] === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL fp_out unexpected portid %0d required none",
                   opid[0]);
        end else if (out_ready) begin
          e = q0.pop_front();
          chk("fp_out", {opid[0], opay[0]}, e);
        end else begin
          chk("fp_hold", {opid[0], opay[0]}, q0[0]);
        end
      end
      if (oval[1] === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rr_out unexpected portid %0d required none",
                   opid[1]);
        end else if (out_ready) begin
          e = q1.pop_front();
          chk("rr_out", {opid[1], opay[1]}, e);
        end else begin
          chk("rr_hold", {opid[1], opay[1]}, q1[0]);
        end
      end
    end
  end

  initial begin
    int first_wake;
    int cnt [2];
    rst = 1'b1; req_valid = '1; pay = '0; out_ready = 1'b1;
    rsp_valid = 1'b0; rsp_portid = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_ready", rdy[m], 0);
      chk("rst_out_valid", oval[m], 0);
      chk("rst_payload", opay[m], 0);
      chk("rst_portid", opid[m], 0);
      chk("rst_wake", wd[m], 0);
      chk("rst_err", er[m], 0);
    end
    model_reset();

    first_wake = -1;
    for (int k = 0; k < 24; k++) begin
      cyc('1, 1, 0, 0, 0);
      if (first_wake < 0 && wd[0] === 1'b1) first_wake = k;
      if (k == WK) begin
        chk("first_grant_fp", rdy[0], 1);
        chk("first_grant_rr", rdy[1], 1);
      end
      if (k >= WK && k <= WK + 6)
        chk("rr_sequence", rdy[1], 1 << ((k - WK) % N));
    end
    chk("wake_cycle", first_wake, WK);

    for (int k = 0; k < 400; k++) begin
      int rp;
      rp = ($urandom_range(0, 9) == 0) ? 6 + $urandom_range(0, 1)
                                       : $urandom_range(0, 5);
      cyc(N'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, rp, 0);
    end

    // Reset while a request is held downstream.
    cyc('1, 0, 0, 0, 0);
    cyc('1, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) cyc('1, 1, 0, 0, 0);

    wake_up();
    for (int k = 0; k < 12; k++) begin
      cyc(6'b001010, 1, os[0][1] > 0, 1, 0);
      chk("fp_port1_only", rdy[0], 6'b000010);
    end

    wake_up();
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(6'b000100, 1, 0, 0, 0);
      for (int m = 0; m < 2; m++) cnt[m] += int'(rdy[m][2]);
    end
    chk("port2_limit", cnt[0], 4);
    cyc(6'b000100, 1, 1, 2, 0);
    for (int m = 0; m < 2; m++) cnt[m] += int'(rdy[m][2]);
    for (int k = 0; k < 5; k++) begin
      cyc(6'b000100, 1, 0, 0, 0);
      for (int m = 0; m < 2; m++) cnt[m] += int'(rdy[m][2]);
    end
    chk("port2_fp_total", cnt[0], 5);
    chk("port2_rr_total", cnt[1], 5);

    cyc(6'b000001, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(6'b000011, 0, 0, 0, 0);
    cyc(6'b000000, 1, 1, 5, 0);
    for (int k = 0; k < 4; k++) cyc(6'b000000, 1, 0, 0, 0);
    chk("err_sticky_fp", er[0], 1);
    chk("err_sticky_rr", er[1], 1);
    cyc('0, 1, 0, 0, 1);
    cyc('0, 1, 0, 0, 0);
    chk("err_cleared", er[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
